// File: rtl/pf_mem_arbiter.sv
// Arbitrates demand and prefetch line traffic onto one cacheline adaptor, demand first.
// Latency: grant in IDLE, request one cycle later, completion forwarded in the mem_resp cycle.
// Backpressure: non-preemptive, so requests hold until served; a demand hitting the in-flight prefetch line merges.
module pf_mem_arbiter #(
  parameter int OFFSET_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cache_read,
  input  logic             cache_write,
  input  logic [31:0]      cache_address,
  input  logic [255:0]     cache_wdata,
  output logic [255:0]     cache_rdata,
  output logic             cache_resp,
  input  logic             pf_read,
  input  logic [31:0]      pf_address,
  output logic [255:0]     pf_rdata,
  output logic             pf_resp,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [255:0]     mem_wdata,
  input  logic [255:0]     mem_rdata,
  input  logic             mem_resp,
  output logic [CNT_W-1:0] pf_issued_cnt,
  output logic [CNT_W-1:0] pf_merged_cnt
);

  localparam int LINE_W = 32 - OFFSET_W;

  typedef enum logic [1:0] {IDLE, DEM_WR, DEM_RD, PF_RD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LINE_W-1:0] line_q;
  logic [255:0]      wdata_q;
  logic [LINE_W-1:0] last_pf_line;
  logic              last_pf_valid;

  logic              grant_load;
  logic              grant_wr;
  logic              grant_pf;
  logic [31:0]       grant_addr;
  logic              pf_eligible;
  logic              merge_hit;

  // Offset bits never reach memory: requests are always whole lines.
  logic unused_offsets;
  assign unused_offsets = ^{cache_address[OFFSET_W-1:0], pf_address[OFFSET_W-1:0]};

  assign mem_address = {line_q, {OFFSET_W{1'b0}}};
  assign mem_wdata   = wdata_q;

  // A sticky pf_read for the line just fetched must not hit memory again.
  assign pf_eligible = pf_read &&
                       !(last_pf_valid && (pf_address[31:OFFSET_W] == last_pf_line));

  // A demand read for the line currently being prefetched shares the response.
  // A concurrent writeback takes precedence, so no merge while cache_write is high.
  assign merge_hit = (state == PF_RD) && mem_resp && cache_read && !cache_write &&
                     (cache_address[31:OFFSET_W] == line_q);

  // State register, latched grant, prefetch history and saturating statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      line_q        <= '0;
      wdata_q       <= '0;
      last_pf_line  <= '0;
      last_pf_valid <= 1'b0;
      pf_issued_cnt <= '0;
      pf_merged_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_load) begin
        line_q <= grant_addr[31:OFFSET_W];
      end
      if (grant_wr) begin
        wdata_q <= cache_wdata;
      end
      if (grant_pf && (pf_issued_cnt != {CNT_W{1'b1}})) begin
        pf_issued_cnt <= pf_issued_cnt + 1'b1;
      end
      if ((state == PF_RD) && mem_resp) begin
        last_pf_line  <= line_q;
        last_pf_valid <= 1'b1;
      end
      if (merge_hit && (pf_merged_cnt != {CNT_W{1'b1}})) begin
        pf_merged_cnt <= pf_merged_cnt + 1'b1;
      end
    end
  end

  // Grant selection, request drive and combinational completion routing.
  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cache_resp  = 1'b0;
    cache_rdata = '0;
    pf_resp     = 1'b0;
    pf_rdata    = '0;
    grant_load  = 1'b0;
    grant_wr    = 1'b0;
    grant_pf    = 1'b0;
    grant_addr  = cache_address;
    case (state)
      IDLE: begin
        if (cache_write) begin
          grant_load = 1'b1;
          grant_wr   = 1'b1;
          state_nxt  = DEM_WR;
        end else if (cache_read) begin
          grant_load = 1'b1;
          state_nxt  = DEM_RD;
        end else if (pf_eligible) begin
          grant_load = 1'b1;
          grant_pf   = 1'b1;
          grant_addr = pf_address;
          state_nxt  = PF_RD;
        end
      end
      DEM_WR, DEM_RD: begin
        mem_write = (state == DEM_WR);
        mem_read  = (state == DEM_RD);
        if (mem_resp) begin
          cache_resp  = 1'b1;
          cache_rdata = mem_rdata;
          state_nxt   = IDLE;
        end
      end
      PF_RD: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          pf_resp   = 1'b1;
          pf_rdata  = mem_rdata;
          state_nxt = IDLE;
          if (merge_hit) begin
            cache_resp  = 1'b1;
            cache_rdata = mem_rdata;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pf_mem_arbiter.sv
// Bench for pf_mem_arbiter: queue scoreboard of memory requests and responses.
// Latency: memory model answers a configurable number of cycles after a request.
// Backpressure: demand inputs held until cache_resp, as the L2 side would.
module tb_pf_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         cache_read, cache_write;
  logic [31:0]  cache_address;
  logic [255:0] cache_wdata, cache_rdata;
  logic         cache_resp;
  logic         pf_read;
  logic [31:0]  pf_address;
  logic [255:0] pf_rdata;
  logic         pf_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pf_issued_cnt, pf_merged_cnt;

  int checks = 0;
  int passed = 0;
  int mem_lat = 3;
  int mem_req_cnt = 0;
  bit mon_en = 1'b0;
  bit saw_resp = 1'b0;

  logic [255:0] exp_cache[$];
  logic [255:0] exp_pf[$];
  logic [32:0]  exp_mem[$];

  always #5 clk = ~clk;

  pf_mem_arbiter #(.OFFSET_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_address(cache_address), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_resp(cache_resp),
    .pf_read(pf_read), .pf_address(pf_address),
    .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pf_issued_cnt(pf_issued_cnt), .pf_merged_cnt(pf_merged_cnt)
  );

  function automatic logic [255:0] line_data(input logic [31:0] a);
    return {8{a ^ 32'hC3A5_5A3C}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: accepts a request, answers mem_lat cycles later for one cycle.
  task automatic run_mem_model();
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [31:0] addr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      if (busy) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          mem_resp  = 1'b1;
          mem_rdata = line_data(addr);
          saw_resp  = 1'b1;
          busy      = 1'b0;
        end
      end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
        busy = 1'b1;
        cnt  = mem_lat;
        addr = mem_address;
      end
    end
  endtask

  // Scoreboard monitor: pops expected requests and responses as they appear.
  task automatic run_monitor();
    logic         prev_req = 1'b0;
    logic         req;
    logic [255:0] ed;
    logic [32:0]  em;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (cache_resp === 1'b1) begin
          if (exp_cache.size() == 0) $display("FAIL cache_resp_unexpected rdata=%h", cache_rdata);
          else begin
            ed = exp_cache.pop_front();
            if (cache_rdata !== ed) $display("FAIL cache_rdata got=%h exp=%h", cache_rdata, ed);
            else passed++;
          end
        end else if (cache_rdata !== '0) $display("FAIL cache_rdata_idle got=%h exp=0", cache_rdata);
        else passed++;
        checks++;
        if (pf_resp === 1'b1) begin
          if (exp_pf.size() == 0) $display("FAIL pf_resp_unexpected rdata=%h", pf_rdata);
          else begin
            ed = exp_pf.pop_front();
            if (pf_rdata !== ed) $display("FAIL pf_rdata got=%h exp=%h", pf_rdata, ed);
            else passed++;
          end
        end else if (pf_rdata !== '0) $display("FAIL pf_rdata_idle got=%h exp=0", pf_rdata);
        else passed++;
        req = (mem_read === 1'b1) || (mem_write === 1'b1);
        if (req && !prev_req) begin
          mem_req_cnt++;
          checks++;
          if (exp_mem.size() == 0) $display("FAIL mem_req_unexpected wr=%b addr=%h", mem_write, mem_address);
          else begin
            em = exp_mem.pop_front();
            if ({mem_write, mem_address} !== em) $display("FAIL mem_req got=%h exp=%h", {mem_write, mem_address}, em);
            else passed++;
          end
        end
        prev_req = req;
      end
    end
  endtask

  // Waits on a DUT output: 0 pf_resp, 1 cache_resp, 2 memory request. cyc=-1 on timeout.
  task automatic wait_sig(input int sel, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((sel == 0 && pf_resp === 1'b1) || (sel == 1 && cache_resp === 1'b1) ||
          (sel == 2 && (mem_read === 1'b1 || mem_write === 1'b1))) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cache_read = 0; cache_write = 0; cache_address = '0; cache_wdata = '0;
    pf_read = 0; pf_address = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, cache_resp, pf_resp} !== 4'b0 || mem_address !== '0 ||
        mem_wdata !== '0 || cache_rdata !== '0 || pf_rdata !== '0)
      $display("FAIL reset_outputs rd=%b wr=%b cr=%b pr=%b addr=%h", mem_read, mem_write, cache_resp, pf_resp, mem_address);
    else passed++;
    checks++;
    if (pf_issued_cnt !== 16'd0 || pf_merged_cnt !== 16'd0)
      $display("FAIL reset_counters issued=%0d merged=%0d exp=0", pf_issued_cnt, pf_merged_cnt);
    else passed++;
    step();
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_pf_basic();
    int cyc;
    mem_lat = 3;
    step();
    pf_read = 1; pf_address = 32'h1000_0020;
    exp_mem.push_back({1'b0, 32'h1000_0020});
    exp_pf.push_back(line_data(32'h1000_0020));
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0) $display("FAIL pf_grant_cycle mem_read=%b exp=0", mem_read); else passed++;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h1000_0020)
      $display("FAIL pf_request mem_read=%b addr=%h exp=1/10000020", mem_read, mem_address);
    else passed++;
    wait_sig(0, 20, cyc);
    checks++;
    if (cyc !== 3) $display("FAIL pf_resp_latency got=%0d exp=3", cyc); else passed++;
    step();
    @(negedge clk);
    checks++;
    if (pf_resp !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL pf_resp_width pf_resp=%b mem_read=%b exp=0/0", pf_resp, mem_read);
    else passed++;
    checks++;
    if (pf_issued_cnt !== 16'd1) $display("FAIL pf_issued_1 got=%0d exp=1", pf_issued_cnt); else passed++;
  endtask

  task automatic test_pf_sticky();
    int cyc;
    int n0;
    n0 = mem_req_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (mem_req_cnt !== n0) $display("FAIL pf_sticky_repeat reqs=%0d exp=%0d", mem_req_cnt, n0); else passed++;
    step();
    pf_address = 32'h1000_0040;
    exp_mem.push_back({1'b0, 32'h1000_0040});
    exp_pf.push_back(line_data(32'h1000_0040));
    wait_sig(2, 10, cyc);
    checks++;
    if (cyc < 0) $display("FAIL pf_new_line_issue got=timeout exp=request"); else passed++;
    wait_sig(0, 20, cyc);
    checks++;
    if (cyc < 0) $display("FAIL pf_new_line_resp got=timeout exp=pf_resp"); else passed++;
    step();
    pf_read = 0;
    checks++;
    if (pf_issued_cnt !== 16'd2) $display("FAIL pf_issued_2 got=%0d exp=2", pf_issued_cnt); else passed++;
  endtask

  task automatic test_wr_priority();
    int cyc;
    logic [255:0] w;
    w = {8{32'hDEAD_BEEF}};
    step();
    cache_write = 1; cache_address = 32'h4000_0000; cache_wdata = w;
    pf_read = 1; pf_address = 32'h5000_0000;
    exp_mem.push_back({1'b1, 32'h4000_0000});
    exp_mem.push_back({1'b0, 32'h5000_0000});
    exp_cache.push_back(line_data(32'h4000_0000));
    exp_pf.push_back(line_data(32'h5000_0000));
    wait_sig(2, 10, cyc);
    checks++;
    if (mem_write !== 1'b1 || mem_wdata !== w)
      $display("FAIL wr_first mem_write=%b wdata=%h exp=1/%h", mem_write, mem_wdata, w);
    else passed++;
    wait_sig(1, 20, cyc);
    step();
    cache_write = 0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0) $display("FAIL wr_idle_gap mem_read=%b exp=0", mem_read); else passed++;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) $display("FAIL pf_after_wr mem_read=%b exp=1", mem_read); else passed++;
    wait_sig(0, 20, cyc);
    checks++;
    if (cyc < 0) $display("FAIL pf_after_wr_resp got=timeout exp=pf_resp"); else passed++;
    step();
    pf_read = 0;
  endtask

  task automatic test_merge();
    int cyc;
    int n0;
    mem_lat = 4;
    step();
    pf_read = 1; pf_address = 32'h2000_0020;
    exp_mem.push_back({1'b0, 32'h2000_0020});
    exp_pf.push_back(line_data(32'h2000_0020));
    exp_cache.push_back(line_data(32'h2000_0020));
    wait_sig(2, 10, cyc);
    step();
    cache_read = 1; cache_address = 32'h2000_0024;
    n0 = mem_req_cnt;
    wait_sig(0, 20, cyc);
    checks++;
    if (cyc < 0 || cache_resp !== 1'b1)
      $display("FAIL merge_same_cycle cache_resp=%b cyc=%0d exp=1", cache_resp, cyc);
    else passed++;
    step();
    cache_read = 0; pf_read = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_req_cnt !== n0) $display("FAIL merge_no_reissue reqs=%0d exp=%0d", mem_req_cnt, n0); else passed++;
    checks++;
    if (pf_merged_cnt !== 16'd1) $display("FAIL merged_cnt got=%0d exp=1", pf_merged_cnt); else passed++;
  endtask

  task automatic test_no_merge();
    int cyc;
    mem_lat = 3;
    step();
    pf_read = 1; pf_address = 32'h6000_0000;
    exp_mem.push_back({1'b0, 32'h6000_0000});
    exp_mem.push_back({1'b0, 32'h3000_0000});
    exp_pf.push_back(line_data(32'h6000_0000));
    exp_cache.push_back(line_data(32'h3000_0000));
    wait_sig(2, 10, cyc);
    step();
    cache_read = 1; cache_address = 32'h3000_0000;
    wait_sig(0, 20, cyc);
    checks++;
    if (cyc < 0 || cache_resp !== 1'b0)
      $display("FAIL no_merge_resp cache_resp=%b cyc=%0d exp=0", cache_resp, cyc);
    else passed++;
    step();
    pf_read = 0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0) $display("FAIL no_merge_idle mem_read=%b exp=0", mem_read); else passed++;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h3000_0000)
      $display("FAIL demand_after_pf mem_read=%b addr=%h exp=1/30000000", mem_read, mem_address);
    else passed++;
    wait_sig(1, 20, cyc);
    checks++;
    if (cyc < 0) $display("FAIL demand_after_pf_resp got=timeout exp=cache_resp"); else passed++;
    step();
    cache_read = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    mem_lat = 6;
    saw_resp = 1'b0;
    step();
    cache_read = 1; cache_address = 32'h7000_0040;
    exp_mem.push_back({1'b0, 32'h7000_0040});
    wait_sig(2, 10, cyc);
    step();
    rst = 1'b0; cache_read = 0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, cache_resp, pf_resp} !== 4'b0 || mem_address !== '0 ||
        mem_wdata !== '0 || cache_rdata !== '0 || pf_rdata !== '0)
      $display("FAIL reset_mid_outputs rd=%b wr=%b cr=%b addr=%h exp=0", mem_read, mem_write, cache_resp, mem_address);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (cache_resp !== 1'b0 || pf_resp !== 1'b0 || mem_read !== 1'b0)
        $display("FAIL late_resp_dropped cr=%b pr=%b rd=%b exp=0", cache_resp, pf_resp, mem_read);
      else passed++;
    end
    checks++;
    if (saw_resp !== 1'b1) $display("FAIL late_resp_sent got=%b exp=1", saw_resp); else passed++;
    checks++;
    if (pf_issued_cnt !== 16'd0 || pf_merged_cnt !== 16'd0)
      $display("FAIL reset_mid_counters issued=%0d merged=%0d exp=0", pf_issued_cnt, pf_merged_cnt);
    else passed++;
  endtask

  initial begin
    mem_resp = 1'b0;
    mem_rdata = '0;
    fork
      run_mem_model();
      run_monitor();
    join_none
    test_reset();
    test_pf_basic();
    test_pf_sticky();
    test_wr_priority();
    test_merge();
    test_no_merge();
    test_reset_mid();
    checks++;
    if (exp_cache.size() != 0 || exp_pf.size() != 0 || exp_mem.size() != 0)
      $display("FAIL scoreboard_drain cache=%0d pf=%0d mem=%0d exp=0", exp_cache.size(), exp_pf.size(), exp_mem.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
